// File: rtl/pc_gen_bp.sv
// Fetch PC generator with a direct-mapped 2-bit branch history table and branch target buffer.
// Drives the fetch PC and a taken prediction for that PC into the IF stage.
module pc_gen_bp #(
  parameter int          IDX_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        stall_in,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_pc_in,
  input  logic        upd_valid_in,
  input  logic [31:0] upd_pc_in,
  input  logic        upd_taken_in,
  input  logic [31:0] upd_target_in,
  output logic [31:0] pc_out,
  output logic        branch_predicate_or_not_out
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // Flow control: rdy_in=0 freezes every register and ignores all other inputs.
  // With rdy_in=1, jump_flag_in beats stall_in, and stall_in holds the PC;
  // there is no other handshake with IF. Table updates ignore stall and jump.

  logic [1:0]         ctr_q    [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]    rd_tag;
  logic [TAG_W-1:0]    wr_tag;
  logic                hit;
  logic                pred;
  logic [31:0]         next_seq;
  logic                upd_en;
  logic                unused_pc_lsbs;

  assign rd_idx = pc_out[IDX_BITS+1:2];
  assign rd_tag = pc_out[31:IDX_BITS+2];
  assign wr_idx = upd_pc_in[IDX_BITS+1:2];
  assign wr_tag = upd_pc_in[31:IDX_BITS+2];
  assign unused_pc_lsbs = ^upd_pc_in[1:0];

  // Lookup reads registered tables only, so a same-cycle write is not bypassed.
  assign hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred     = hit && ctr_q[rd_idx][1];
  assign next_seq = pred ? target_q[rd_idx] : (pc_out + 32'd4);
  assign branch_predicate_or_not_out = pred;

  assign upd_en = rdy_in && upd_valid_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_out <= RESET_PC;
    end else if (rdy_in) begin
      if (jump_flag_in) begin
        pc_out <= jump_pc_in;
      end else if (!stall_in) begin
        pc_out <= next_seq;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
      valid_q <= '0;
    end else if (upd_en) begin
      if (upd_taken_in) begin
        if (ctr_q[wr_idx] != 2'b11) begin
          ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
        end
        valid_q[wr_idx] <= 1'b1;
      end else if (ctr_q[wr_idx] != 2'b00) begin
        ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
      end
    end
  end

  // Tag and target need no reset: they are only observed through valid_q.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && upd_en && upd_taken_in) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= upd_target_in;
    end
  end

endmodule

// File: tb/tb_pc_gen_bp.sv
// Directed self-checking bench for pc_gen_bp: sequencing, BHT/BTB training,
// stall/jump/ready priority, tag aliasing, asynchronous reset and PC wrap.
module tb_pc_gen_bp;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        stall;
  logic        jump_flag;
  logic [31:0] jump_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  pc_gen_bp #(.IDX_BITS(6), .RESET_PC(32'h0)) dut (
    .clk_in                      (clk),
    .rst_n_in                    (rst_n),
    .rdy_in                      (rdy),
    .stall_in                    (stall),
    .jump_flag_in                (jump_flag),
    .jump_pc_in                  (jump_pc),
    .upd_valid_in                (upd_valid),
    .upd_pc_in                   (upd_pc),
    .upd_taken_in                (upd_taken),
    .upd_target_in               (upd_target),
    .pc_out                      (pc),
    .branch_predicate_or_not_out (pred)
  );

  // Clock/reset: rising edge is active; the bench drives and samples on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rdy        = 1'b1;
    stall      = 1'b0;
    jump_flag  = 1'b0;
    jump_pc    = 32'h0;
    upd_valid  = 1'b0;
    upd_pc     = 32'h0;
    upd_taken  = 1'b0;
    upd_target = 32'h0;
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic drive_jump(input logic [31:0] target);
    jump_flag = 1'b1;
    jump_pc   = target;
  endtask

  task automatic drive_upd(input logic [31:0] upc, input logic taken, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = upc;
    upd_taken  = taken;
    upd_target = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    cycle();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL reset_pred got=%b exp=0", pred); end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [31:0] exp;
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    while (exp_q.size() > 0) begin
      cycle();
      exp = exp_q.pop_front();
      checks++; if (pc !== exp) begin errors++; $display("FAIL free_run_pc got=%h exp=%h", pc, exp); end
      checks++; if (pred !== 1'b0) begin errors++; $display("FAIL free_run_pred got=%b exp=0", pred); end
    end
  endtask

  task automatic test_train_taken();
    drive_upd(32'h10, 1'b1, 32'h80);
    drive_jump(32'h8);
    cycle();
    clear_inputs();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL train_jump_pc got=%h exp=%h", pc, 32'h8); end
    cycle();
    cycle();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL train_reach_pc got=%h exp=%h", pc, 32'h10); end
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL train_pred got=%b exp=1", pred); end
    cycle();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL train_target_pc got=%h exp=%h", pc, 32'h80); end
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL train_target_pred got=%b exp=0", pred); end
  endtask

  task automatic test_not_taken();
    drive_upd(32'h10, 1'b0, 32'h0);
    cycle();
    drive_jump(32'h10);
    cycle();
    clear_inputs();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL nt_pc got=%h exp=%h", pc, 32'h10); end
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL nt_pred got=%b exp=0", pred); end
    // Third not-taken update while stalled: counter must stay at 00.
    stall = 1'b1;
    drive_upd(32'h10, 1'b0, 32'h0);
    cycle();
    clear_inputs();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL nt_hold_pc got=%h exp=%h", pc, 32'h10); end
    cycle();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL nt_seq_pc got=%h exp=%h", pc, 32'h14); end
    // One taken step from a saturated 00 gives 01, still predicting not-taken.
    drive_upd(32'h10, 1'b1, 32'h80);
    drive_jump(32'h10);
    cycle();
    clear_inputs();
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL nt_saturate_pred got=%b exp=0", pred); end
  endtask

  task automatic test_stall_jump();
    stall = 1'b1;
    drive_jump(32'h200);
    cycle();
    jump_flag = 1'b0;
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL stall_jump_pc got=%h exp=%h", pc, 32'h200); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (pc !== 32'h200) begin errors++; $display("FAIL stall_hold_pc cyc=%0d got=%h exp=%h", i, pc, 32'h200); end
    end
    clear_inputs();
    rdy = 1'b0;
    drive_upd(32'h200, 1'b1, 32'h400);
    drive_jump(32'h500);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (pc !== 32'h200) begin errors++; $display("FAIL rdy_hold_pc cyc=%0d got=%h exp=%h", i, pc, 32'h200); end
      checks++; if (pred !== 1'b0) begin errors++; $display("FAIL rdy_hold_pred cyc=%0d got=%b exp=0", i, pred); end
    end
    clear_inputs();
    cycle();
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL rdy_release_pc got=%h exp=%h", pc, 32'h204); end
  endtask

  task automatic test_alias();
    drive_upd(32'h10, 1'b1, 32'h80);
    drive_jump(32'h10);
    cycle();
    clear_inputs();
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL alias_pre_pred got=%b exp=1", pred); end
    stall = 1'b1;
    drive_upd(32'h110, 1'b1, 32'h300);
    cycle();
    clear_inputs();
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL alias_miss_pred got=%b exp=0", pred); end
    drive_jump(32'h110);
    cycle();
    clear_inputs();
    checks++; if (pred !== 1'b1) begin errors++; $display("FAIL alias_hit_pred got=%b exp=1", pred); end
    cycle();
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL alias_target_pc got=%h exp=%h", pc, 32'h300); end
  endtask

  task automatic test_async_reset();
    drive_jump(32'h80);
    cycle();
    clear_inputs();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL areset_pre_pc got=%h exp=%h", pc, 32'h80); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL areset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL areset_pred got=%b exp=0", pred); end
    cycle();
    rst_n = 1'b1;
    drive_jump(32'h110);
    cycle();
    clear_inputs();
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL areset_trained_pred got=%b exp=0", pred); end
    cycle();
    checks++; if (pc !== 32'h114) begin errors++; $display("FAIL areset_seq_pc got=%h exp=%h", pc, 32'h114); end
  endtask

  task automatic test_wrap();
    drive_jump(32'hFFFF_FFFC);
    cycle();
    clear_inputs();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    checks++; if (pred !== 1'b0) begin errors++; $display("FAIL wrap_pred got=%b exp=0", pred); end
    cycle();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_train_taken();
    test_not_taken();
    test_stall_jump();
    test_alias();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
